ysyx_23060240_sram_arbiter: RTL and testbench
=============================================

// Module: ysyx_23060240_sram_arbiter
// PURPOSE
//  Shares the single DPI-backed pmem SRAM port between the IFU (read-only) and the LSU (read/write).
//  Accepts one request at a time via valid/ready, drives it to the SRAM with a req/gnt handshake,
//  and buffers the single response until the owning requester takes it.
//  Sits between the IFU/LSU and the SRAM model; at most one transaction is outstanding.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width; mask width is DATA_W/8
//  ARB_MODE  0   0 = round-robin on contention; 1 = LSU fixed priority
// PORTS
//  clk          in   1         clock; all logic on posedge
//  rst_n        in   1         synchronous, active-low reset
//  ifu_valid    in   1         IFU read request
//  ifu_ready    out  1         IFU request accepted this cycle (valid&ready)
//  ifu_addr     in   ADDR_W    IFU fetch address
//  ifu_rvalid   out  1         IFU response valid
//  ifu_rready   in   1         IFU takes response
//  ifu_rdata    out  DATA_W    IFU read data
//  lsu_valid    in   1         LSU request
//  lsu_ready    out  1         LSU request accepted this cycle
//  lsu_addr     in   ADDR_W    LSU address
//  lsu_wen      in   1         1 = write, 0 = read
//  lsu_wdata    in   DATA_W    LSU write data
//  lsu_wmask    in   DATA_W/8  byte write mask
//  lsu_rvalid   out  1         LSU completion; read data valid when the request was a read
//  lsu_rready   in   1         LSU takes completion
//  lsu_rdata    out  DATA_W    LSU read data (0 for write completions)
//  mem_req      out  1         SRAM request; held until mem_gnt
//  mem_gnt      in   1         SRAM accepts request
//  mem_addr     out  ADDR_W    latched address
//  mem_wen      out  1         latched write enable (0 for IFU)
//  mem_wdata    out  DATA_W    latched write data
//  mem_wmask    out  DATA_W/8  latched mask (0 for IFU and LSU reads)
//  mem_rvalid   in   1         SRAM response pulse (one cycle)
//  mem_rdata    in   DATA_W    SRAM read data, valid with mem_rvalid
// BEHAVIOUR
//  States: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//  IDLE: select a winner among valid requesters; the winner's ready is 1 (combinational from valid + state),
//    the loser's ready is 0. On acceptance, latch addr/wen/wdata/wmask and owner, then go to REQ.
//  Arbitration: round-robin uses last_owner (reset = IFU, so the first tie goes to LSU); the winner
//    becomes last_owner. ARB_MODE=1 makes LSU always win ties. A single valid requester always wins.
//  REQ: mem_req=1 and mem_* stable until mem_gnt. On gnt go to WAIT; if mem_rvalid also arrives that
//    cycle, capture the data and go directly to RESP.
//  WAIT: mem_req=0. On mem_rvalid capture rdata (0 if the access was a write), go to RESP.
//  RESP: owner's rvalid=1 with stable rdata until its rready; on rready return to IDLE.
//    The non-owner's rvalid stays 0. No new request is accepted until IDLE (ready=0 in REQ/WAIT/RESP).
//  Latency: accept at T -> mem_req at T+1; with gnt at T+1 and rvalid at T+2, rvalid to the
//    requester at T+3. Minimum is T+2 (gnt and rvalid both at T+1). Back-to-back requests: accept
//    again in the cycle after rready.
//  mem_rvalid in IDLE, RESP or REQ-without-gnt is ignored; no state or data change.
//  Reset (any state): state=IDLE, last_owner=IFU; mem_req, ifu_ready, lsu_ready, ifu_rvalid and lsu_rvalid
//    are 0; rdata, mem_addr, mem_wdata, mem_wmask and mem_wen are 0. An in-flight transaction is
//    dropped; a late mem_rvalid after reset is ignored.
//  Requester valid dropping while not ready: no effect. Address changes while not accepted: ignored.
// TESTING
//  1 IFU alone: ifu_valid, addr=0x80000000; SRAM gnt at +1, rvalid at +2 with 0x00000413 ->
//    ifu_rvalid at T+3, rdata=0x00000413; lsu_rvalid stays 0.
//  2 LSU write: addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF -> mem_wen=1 and mask=0xF held while
//    gnt=0 for 3 cycles; lsu_rvalid with rdata=0 after rvalid.
//  3 Tie after reset, ARB_MODE=0: both valid for 3 transactions -> owners are LSU, IFU, LSU.
//    With ARB_MODE=1 all 3 are LSU.
//  4 Backpressure: hold ifu_rready=0 for 5 cycles -> ifu_rvalid/rdata stable, both readys 0,
//    mem_req 0; the queued LSU request is accepted in the cycle after rready.
//  5 Fast slave: gnt and rvalid in the same cycle -> REQ->RESP directly, rvalid to the requester at T+2.
//  6 Reset in WAIT, then mem_rvalid pulse -> all outputs 0, state IDLE, pulse ignored, no rvalid.

Source files
------------

// File: rtl/ysyx_23060240_sram_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the SRAM arbiter and the pmem SRAM port.
// master: the arbiter's view. It answers requesters and drives the SRAM request.
// slave: the environment's view. It covers the requesters and the SRAM model.
interface ysyx_23060240_sram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // IFU read port
  logic              ifu_valid;
  logic              ifu_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rvalid;
  logic              ifu_rready;
  logic [DATA_W-1:0] ifu_rdata;
  // LSU read/write port
  logic                lsu_valid;
  logic                lsu_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_rvalid;
  logic                lsu_rready;
  logic [DATA_W-1:0]   lsu_rdata;
  // SRAM port
  logic                mem_req;
  logic                mem_gnt;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    input  ifu_valid, ifu_addr, ifu_rready,
    input  lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rready,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ifu_ready, ifu_rvalid, ifu_rdata,
    output lsu_ready, lsu_rvalid, lsu_rdata,
    output mem_req, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport slave (
    output ifu_valid, ifu_addr, ifu_rready,
    output lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rready,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ifu_ready, ifu_rvalid, ifu_rdata,
    input  lsu_ready, lsu_rvalid, lsu_rdata,
    input  mem_req, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_23060240_sram_arbiter.sv
// Shares the single pmem SRAM port between the IFU (read-only) and the LSU (read/write).
// The arbiter keeps one transaction in flight: accept, req/gnt, wait for data, hold the response.
module ysyx_23060240_sram_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 0   // 0: round-robin on ties, 1: LSU always wins ties
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_23060240_sram_arbiter_if.master  bus
);

  localparam int unsigned MASK_W = DATA_W / 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic OwnIfu = 1'b0;
  localparam logic OwnLsu = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic lsu_win, ifu_win, owner_rready;

  // Pick the winner among valid requesters; ready is only offered in IDLE and out of reset.
  always_comb begin
    // LSU wins when alone, in fixed-priority mode, or when IFU owned the last transaction.
    lsu_win       = bus.lsu_valid &
                    (~bus.ifu_valid | (ARB_MODE != 0) | (last_owner_q == OwnIfu));
    ifu_win       = bus.ifu_valid & ~lsu_win;
    bus.ifu_ready = rst_n & (state_q == StIdle) & ifu_win;
    bus.lsu_ready = rst_n & (state_q == StIdle) & lsu_win;
    owner_rready  = (owner_q == OwnLsu) ? bus.lsu_rready : bus.ifu_rready;
  end

  // Transaction sequencing: latch on accept, capture read data, release on rready.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.lsu_ready) begin
          state_d      = StReq;
          owner_d      = OwnLsu;
          last_owner_d = OwnLsu;
          addr_d       = bus.lsu_addr;
          wen_d        = bus.lsu_wen;
          wdata_d      = bus.lsu_wdata;
          wmask_d      = bus.lsu_wen ? bus.lsu_wmask : '0;
        end else if (bus.ifu_ready) begin
          state_d      = StReq;
          owner_d      = OwnIfu;
          last_owner_d = OwnIfu;
          addr_d       = bus.ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
        end
      end
      StReq: begin
        // A response is only meaningful once the request has been granted.
        if (bus.mem_gnt) begin
          if (bus.mem_rvalid) begin
            rdata_d = wen_q ? '0 : bus.mem_rdata;
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (bus.mem_rvalid) begin
          rdata_d = wen_q ? '0 : bus.mem_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        if (owner_rready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched transaction; synchronous reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_owner_q <= OwnIfu;
      owner_q      <= OwnIfu;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
    end
  end

  // SRAM and response outputs come straight from registered state.
  always_comb begin
    bus.mem_req    = (state_q == StReq);
    bus.mem_addr   = addr_q;
    bus.mem_wen    = wen_q;
    bus.mem_wdata  = wdata_q;
    bus.mem_wmask  = wmask_q;
    bus.ifu_rvalid = (state_q == StResp) & (owner_q == OwnIfu);
    bus.lsu_rvalid = (state_q == StResp) & (owner_q == OwnLsu);
    bus.ifu_rdata  = rdata_q;
    bus.lsu_rdata  = rdata_q;
  end

endmodule

// File: tb/tb_ysyx_23060240_sram_arbiter.sv
// Bench for the SRAM arbiter. Two instances share one stimulus: instance 0 uses round-robin
// and instance 1 uses LSU fixed priority. A transaction-level model predicts each instance's
// winner, latched SRAM request, response data and the cycle on which each output is expected.
module tb_ysyx_23060240_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ifu_valid, ifu_rready, lsu_valid, lsu_wen, lsu_rready;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [3:0]  lsu_wmask;

  int checks = 0;
  int errors = 0;

  ysyx_23060240_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  ysyx_23060240_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  assign bus0.ifu_valid  = ifu_valid;   assign bus1.ifu_valid  = ifu_valid;
  assign bus0.ifu_addr   = ifu_addr;    assign bus1.ifu_addr   = ifu_addr;
  assign bus0.ifu_rready = ifu_rready;  assign bus1.ifu_rready = ifu_rready;
  assign bus0.lsu_valid  = lsu_valid;   assign bus1.lsu_valid  = lsu_valid;
  assign bus0.lsu_addr   = lsu_addr;    assign bus1.lsu_addr   = lsu_addr;
  assign bus0.lsu_wen    = lsu_wen;     assign bus1.lsu_wen    = lsu_wen;
  assign bus0.lsu_wdata  = lsu_wdata;   assign bus1.lsu_wdata  = lsu_wdata;
  assign bus0.lsu_wmask  = lsu_wmask;   assign bus1.lsu_wmask  = lsu_wmask;
  assign bus0.lsu_rready = lsu_rready;  assign bus1.lsu_rready = lsu_rready;
  assign bus0.mem_gnt    = mem_gnt;     assign bus1.mem_gnt    = mem_gnt;
  assign bus0.mem_rvalid = mem_rvalid;  assign bus1.mem_rvalid = mem_rvalid;
  assign bus0.mem_rdata  = mem_rdata;   assign bus1.mem_rdata  = mem_rdata;

  ysyx_23060240_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  ysyx_23060240_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic        o_ifu_ready [2], o_lsu_ready [2], o_mem_req [2], o_mem_wen [2];
  logic        o_ifu_rvalid [2], o_lsu_rvalid [2];
  logic [31:0] o_mem_addr [2], o_mem_wdata [2], o_ifu_rdata [2], o_lsu_rdata [2];
  logic [3:0]  o_mem_wmask [2];

  assign o_ifu_ready[0]  = bus0.ifu_ready;   assign o_ifu_ready[1]  = bus1.ifu_ready;
  assign o_lsu_ready[0]  = bus0.lsu_ready;   assign o_lsu_ready[1]  = bus1.lsu_ready;
  assign o_mem_req[0]    = bus0.mem_req;     assign o_mem_req[1]    = bus1.mem_req;
  assign o_mem_wen[0]    = bus0.mem_wen;     assign o_mem_wen[1]    = bus1.mem_wen;
  assign o_ifu_rvalid[0] = bus0.ifu_rvalid;  assign o_ifu_rvalid[1] = bus1.ifu_rvalid;
  assign o_lsu_rvalid[0] = bus0.lsu_rvalid;  assign o_lsu_rvalid[1] = bus1.lsu_rvalid;
  assign o_mem_addr[0]   = bus0.mem_addr;    assign o_mem_addr[1]   = bus1.mem_addr;
  assign o_mem_wdata[0]  = bus0.mem_wdata;   assign o_mem_wdata[1]  = bus1.mem_wdata;
  assign o_mem_wmask[0]  = bus0.mem_wmask;   assign o_mem_wmask[1]  = bus1.mem_wmask;
  assign o_ifu_rdata[0]  = bus0.ifu_rdata;   assign o_ifu_rdata[1]  = bus1.ifu_rdata;
  assign o_lsu_rdata[0]  = bus0.lsu_rdata;   assign o_lsu_rdata[1]  = bus1.lsu_rdata;

  // Reference arbitration state: who won the previous transaction (1 = LSU), per instance.
  bit last_lsu [2];
  bit mode_lsu [2] = '{1'b0, 1'b1};

  // Winner rule: a lone requester wins; on a tie LSU wins in fixed-priority mode,
  // otherwise the requester that did not win last time.
  function automatic bit pick_lsu(bit iv, bit lv, bit fixed, bit last);
    if (iv && lv) return fixed ? 1'b1 : !last;
    return lv;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d observed %h expected %h", tag, d, obs, exp);
    end
  endtask

  task automatic chk_ctl(string tag, int d, bit ir, bit lr, bit mq, bit iv, bit lv);
    chk({tag, ".ifu_ready"}, d, 32'(o_ifu_ready[d]), 32'(ir));
    chk({tag, ".lsu_ready"}, d, 32'(o_lsu_ready[d]), 32'(lr));
    chk({tag, ".mem_req"}, d, 32'(o_mem_req[d]), 32'(mq));
    chk({tag, ".ifu_rvalid"}, d, 32'(o_ifu_rvalid[d]), 32'(iv));
    chk({tag, ".lsu_rvalid"}, d, 32'(o_lsu_rvalid[d]), 32'(lv));
  endtask

  task automatic chk_mem(string tag, int d, logic [31:0] a, logic w, logic [31:0] wd,
                         logic [3:0] wm);
    chk({tag, ".mem_addr"}, d, o_mem_addr[d], a);
    chk({tag, ".mem_wen"}, d, 32'(o_mem_wen[d]), 32'(w));
    chk({tag, ".mem_wdata"}, d, o_mem_wdata[d], wd);
    chk({tag, ".mem_wmask"}, d, 32'(o_mem_wmask[d]), 32'(wm));
  endtask

  task automatic chk_zero(string tag);
    for (int d = 0; d < 2; d++) begin
      chk_ctl(tag, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_mem(tag, d, 32'h0, 1'b0, 32'h0, 4'h0);
      chk({tag, ".ifu_rdata"}, d, o_ifu_rdata[d], 32'h0);
      chk({tag, ".lsu_rdata"}, d, o_lsu_rdata[d], 32'h0);
    end
  endtask

  task automatic idle_inputs();
    ifu_valid = 0; lsu_valid = 0; ifu_rready = 0; lsu_rready = 0;
    mem_gnt = 0; mem_rvalid = 0; lsu_wen = 0;
    ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; mem_rdata = '0;
  endtask

  task automatic do_reset(string tag);
    idle_inputs();
    rst_n = 0;
    tick();
    #1;
    chk_zero(tag);
    tick();
    rst_n = 1;
    last_lsu = '{1'b0, 1'b0};
  endtask

  // Requester activity while a transaction is in flight; none of it may be accepted.
  // 0: quiet, 1: LSU request queued, 2: random valids and payloads.
  task automatic busy(int m);
    ifu_addr  = $urandom;
    lsu_addr  = $urandom;
    lsu_wdata = $urandom;
    lsu_wmask = 4'($urandom);
    lsu_wen   = 1'($urandom);
    case (m)
      0:       begin ifu_valid = 0; lsu_valid = 0; end
      1:       begin ifu_valid = 0; lsu_valid = 1; end
      default: begin ifu_valid = 1'($urandom); lsu_valid = 1'($urandom); end
    endcase
  endtask

  // One complete transaction: request, gnt after gnt_dly stalls, read data either with gnt
  // (fast) or rv_dly cycles later, then bp cycles of response backpressure before rready.
  task automatic xact(string tag, bit iv, bit lv, bit lwen, logic [31:0] ia, logic [31:0] la,
                      logic [31:0] wd, logic [3:0] wm, logic [31:0] rd, int gnt_dly, bit fast,
                      int rv_dly, int bp, int bm);
    bit          win [2];
    logic [31:0] ea [2], ewd [2], erd [2];
    logic        ew [2];
    logic [3:0]  em [2];
    ifu_valid = iv; ifu_addr = ia; lsu_valid = lv; lsu_addr = la;
    lsu_wen = lwen; lsu_wdata = wd; lsu_wmask = wm;
    ifu_rready = 0; lsu_rready = 0; mem_gnt = 0; mem_rvalid = 0;
    for (int d = 0; d < 2; d++) begin
      win[d]      = pick_lsu(iv, lv, mode_lsu[d], last_lsu[d]);
      last_lsu[d] = win[d];
      ea[d]  = win[d] ? la : ia;
      ew[d]  = win[d] ? lwen : 1'b0;
      ewd[d] = win[d] ? wd : 32'h0;
      em[d]  = (win[d] && lwen) ? wm : 4'h0;
      erd[d] = (win[d] && lwen) ? 32'h0 : rd;
    end
    #1;
    for (int d = 0; d < 2; d++) chk_ctl({tag, ".acc"}, d, !win[d], win[d], 0, 0, 0);
    tick();
    for (int i = 0; i < gnt_dly; i++) begin
      busy(bm);
      mem_rvalid = 1'($urandom);  // stray pulse before gnt must be ignored
      mem_rdata  = $urandom;
      #1;
      for (int d = 0; d < 2; d++) begin
        chk_ctl({tag, ".req"}, d, 0, 0, 1, 0, 0);
        chk_mem({tag, ".req"}, d, ea[d], ew[d], ewd[d], em[d]);
      end
      tick();
    end
    busy(bm);
    mem_gnt    = 1;
    mem_rvalid = fast;
    mem_rdata  = fast ? rd : $urandom;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_ctl({tag, ".gnt"}, d, 0, 0, 1, 0, 0);
      chk_mem({tag, ".gnt"}, d, ea[d], ew[d], ewd[d], em[d]);
    end
    tick();
    mem_gnt = 0;
    if (!fast) begin
      for (int i = 0; i < rv_dly; i++) begin
        busy(bm);
        mem_rvalid = 0;
        mem_rdata  = $urandom;
        #1;
        for (int d = 0; d < 2; d++) chk_ctl({tag, ".wait"}, d, 0, 0, 0, 0, 0);
        tick();
      end
      busy(bm);
      mem_rvalid = 1;
      mem_rdata  = rd;
      #1;
      for (int d = 0; d < 2; d++) chk_ctl({tag, ".rv"}, d, 0, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i <= bp; i++) begin
      busy(bm);
      mem_rvalid = 1'($urandom);  // late pulses while holding a response are ignored
      mem_rdata  = $urandom;
      ifu_rready = (i == bp);
      lsu_rready = (i == bp);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk_ctl({tag, ".resp"}, d, 0, 0, 0, !win[d], win[d]);
        chk({tag, ".rdata"}, d, win[d] ? o_lsu_rdata[d] : o_ifu_rdata[d], erd[d]);
      end
      tick();
    end
    idle_inputs();
    if (bm == 1) lsu_valid = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit iv, lv;
    do_reset("reset");

    // Ties straight after reset: round-robin gives LSU, IFU, LSU; fixed priority LSU thrice.
    for (int k = 0; k < 3; k++)
      xact("tie", 1, 1, 0, 32'h8000_0100, 32'h8000_0200, 32'h0, 4'h0, $urandom, 0, 0, 0, 0, 0);

    // IFU alone, gnt at T+1, data at T+2, response at T+3.
    xact("ifu", 1, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 4'h0, 32'h0000_0413, 0, 0, 0, 0, 0);

    // LSU write stalled three cycles without gnt; completion carries zero data.
    xact("lsu_wr", 0, 1, 1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678,
         3, 0, 0, 0, 0);

    // Backpressure with an LSU request queued, then that request accepted right after rready.
    xact("bp", 1, 0, 0, 32'h8000_0040, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 0, 0, 5, 1);
    xact("queued", 0, 1, 0, 32'h0, 32'h8000_2000, 32'h5555_AAAA, 4'h3, 32'h0BAD_F00D,
         1, 0, 1, 0, 0);

    // Fast slave: gnt and data together, response at T+2.
    xact("fast", 0, 1, 0, 32'h0, 32'h8000_3000, 32'h0, 4'h0, 32'h7777_1111, 0, 1, 0, 0, 0);

    // Reset while waiting for data, then a stale data pulse.
    idle_inputs();
    ifu_valid = 1;
    ifu_addr  = 32'h8000_0080;
    tick();
    ifu_valid = 0;
    mem_gnt   = 1;
    tick();
    mem_gnt = 0;
    rst_n   = 0;
    tick();
    rst_n      = 1;
    mem_rvalid = 1;
    mem_rdata  = 32'hFFFF_0000;
    #1;
    chk_zero("rst_wait");
    tick();
    mem_rvalid = 0;
    #1;
    chk_zero("rst_late");
    last_lsu = '{1'b0, 1'b0};
    xact("tie_rst", 1, 1, 0, 32'h8000_0300, 32'h8000_0400, 32'h0, 4'h0, $urandom, 0, 0, 0, 0, 0);

    // Random traffic with random timing and busy-phase noise.
    for (int k = 0; k < 150; k++) begin
      iv = 1'($urandom);
      lv = 1'($urandom);
      if (!iv && !lv) lv = 1;
      xact("rand", iv, lv, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom), $urandom,
           int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
